// File: rtl/hi6110_pkg.sv
// Shared constants and types for the HI-6110 host-bus responder.
package hi6110_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [3:0] REG_CTRL       = 4'h0;
  localparam logic [3:0] REG_STATUS     = 4'h1;
  localparam logic [3:0] REG_TXDATA     = 4'h2;
  localparam logic [3:0] REG_RXDATA     = 4'h3;
  localparam logic [3:0] REG_RTADDR     = 4'h4;
  localparam logic [3:0] REG_SCRATCH_LO = 4'h5;

  localparam int unsigned ST_RX_EMPTY  = 0;
  localparam int unsigned ST_RX_FULL   = 1;
  localparam int unsigned ST_TX_EMPTY  = 2;
  localparam int unsigned ST_TX_FULL   = 3;
  localparam int unsigned ST_TX_OVF    = 4;
  localparam int unsigned ST_RX_OVF    = 5;
  localparam int unsigned ST_RX_UNF    = 6;
  localparam int unsigned ST_PROTO_ERR = 7;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StCommit
  } bus_state_e;

  function automatic logic [7:0] sat_count8(input logic [31:0] cnt);
    return (cnt > 32'd255) ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/hi6110_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is accepted only
// when a pop in the same cycle frees the head slot.
module hi6110_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/hi6110_bus_responder.sv
// HI-6110 host register bus responder with RX/TX FIFOs and status pins.
// Define HI6110_BUS_CHECK_EN to enable bus protocol checking (STATUS bit7).
module hi6110_bus_responder #(
  parameter int unsigned DATA_W     = hi6110_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned RT_ADDR_W  = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [3:0]           reg_addr,
  input  logic [DATA_W-1:0]    reg_data_i,
  output logic [DATA_W-1:0]    reg_data_o,
  output logic                 reg_data_oe,
  input  logic                 cs,
  input  logic                 rw,
  input  logic                 str,
  input  logic                 mr,
  input  logic [RT_ADDR_W-1:0] rt_addr,
  input  logic                 rx_push,
  input  logic [DATA_W-1:0]    rx_word,
  input  logic                 tx_pop,
  output logic [DATA_W-1:0]    tx_word,
  output logic                 tx_valid,
  output logic                 ffempty,
  output logic                 rflag,
  output logic                 error
);

  import hi6110_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  bus_state_e state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic       str_q;
  logic       commit;
  logic       oe_q, oe_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] status_w;
  logic [DATA_W-1:0] rf_q [16];

  logic [ST_PROTO_ERR:ST_TX_OVF] sticky_q, sticky_d, sticky_set, sticky_clr;
  logic proto_set;

  logic              wr_commit, rd_commit, rf_we, driving;
  logic              tx_push, rx_pop;
  logic [DATA_W-1:0] rx_head, tx_head;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0]     rx_count, tx_count;
  logic              unused_tx_count;

  assign unused_tx_count = ^tx_count;

  // Bus FSM; a master reset overrides everything and suppresses the commit.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!cs && !str && str_q) begin
          state_d = StActive;
          addr_d  = reg_addr;
          rw_d    = rw;
        end
      end
      StActive: begin
        if (cs) begin
          state_d = StIdle;
        end else if (str) begin
          state_d = StCommit;
          commit  = 1'b1;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (mr) begin
      state_d = StIdle;
      commit  = 1'b0;
    end
  end

  assign wr_commit = commit && !rw_q;
  assign rd_commit = commit && rw_q;
  assign tx_push   = wr_commit && (addr_q == REG_TXDATA);
  assign rx_pop    = rd_commit && (addr_q == REG_RXDATA);
  assign rf_we     = wr_commit && ((addr_q == REG_CTRL) || (addr_q >= REG_SCRATCH_LO));

  // Drive only while the access stays active, so oe drops in COMMIT/abort/mr.
  assign driving = (state_q == StActive) && (state_d == StActive) && rw_q;

  always_comb begin
    status_w                          = '0;
    status_w[ST_RX_EMPTY]             = rx_empty;
    status_w[ST_RX_FULL]              = rx_full;
    status_w[ST_TX_EMPTY]             = tx_empty;
    status_w[ST_TX_FULL]              = tx_full;
    status_w[ST_PROTO_ERR:ST_TX_OVF]  = sticky_q;
    status_w[15:8]                    = sat_count8(32'(rx_count));
  end

  always_comb begin
    rd_mux = '0;
    case (addr_q)
      REG_CTRL:   rd_mux = rf_q[REG_CTRL];
      REG_STATUS: rd_mux = status_w;
      REG_TXDATA: rd_mux = '0;
      REG_RXDATA: rd_mux = rx_head;
      REG_RTADDR: rd_mux = DATA_W'(rt_addr);
      default:    rd_mux = rf_q[addr_q];
    endcase
  end

  assign oe_d    = driving;
  assign rdata_d = driving ? rd_mux : '0;

`ifdef HI6110_BUS_CHECK_EN
  assign proto_set = ((state_q == StActive) && !str && ((reg_addr != addr_q) || (rw != rw_q)))
                   || (!str && str_q && cs);
`else
  assign proto_set = 1'b0;
`endif

  // Sticky errors: set takes priority over a same-cycle write-one-to-clear.
  always_comb begin
    sticky_set               = '0;
    sticky_set[ST_TX_OVF]    = tx_push && tx_full && !(tx_pop && !tx_empty);
    sticky_set[ST_RX_OVF]    = rx_push && rx_full && !(rx_pop && !rx_empty);
    sticky_set[ST_RX_UNF]    = rx_pop && rx_empty;
    sticky_set[ST_PROTO_ERR] = proto_set;
    sticky_clr = (wr_commit && (addr_q == REG_STATUS)) ?
                 reg_data_i[ST_PROTO_ERR:ST_TX_OVF] : '0;
    sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      addr_q   <= REG_CTRL;
      rw_q     <= 1'b0;
      str_q    <= 1'b1;
      oe_q     <= 1'b0;
      rdata_q  <= '0;
      sticky_q <= '0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      str_q    <= mr ? 1'b1 : str;
      oe_q     <= oe_d;
      rdata_q  <= rdata_d;
      sticky_q <= mr ? '0 : sticky_d;
      if (mr) begin
        for (int i = 0; i < 16; i++) begin
          rf_q[i] <= '0;
        end
      end else if (rf_we) begin
        rf_q[addr_q] <= reg_data_i;
      end
    end
  end

  hi6110_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (mr),
    .push  (rx_push),
    .wdata (rx_word),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  hi6110_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (mr),
    .push  (tx_push),
    .wdata (reg_data_i),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign reg_data_o  = rdata_q;
  assign reg_data_oe = oe_q;
  assign tx_word     = tx_head;
  assign tx_valid    = !tx_empty;
  assign ffempty     = rx_empty;
  assign rflag       = !rx_empty;
  assign error       = |sticky_q;

endmodule

// File: tb/tb_hi6110_bus_responder.sv
// Directed bench for hi6110_bus_responder: bus reads checked through a scoreboard queue.
module tb_hi6110_bus_responder;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned RTW   = 5;

  logic           clk = 1'b0;
  logic           rstn;
  logic [3:0]     reg_addr;
  logic [DW-1:0]  reg_data_i, reg_data_o;
  logic           reg_data_oe;
  logic           cs, rw, str, mr;
  logic [RTW-1:0] rt_addr;
  logic           rx_push;
  logic [DW-1:0]  rx_word;
  logic           tx_pop;
  logic [DW-1:0]  tx_word;
  logic           tx_valid, ffempty, rflag, error;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tx_exp_q[$];

  always #5 clk = ~clk;

  hi6110_bus_responder #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .RT_ADDR_W  (RTW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .reg_addr    (reg_addr),
    .reg_data_i  (reg_data_i),
    .reg_data_o  (reg_data_o),
    .reg_data_oe (reg_data_oe),
    .cs          (cs),
    .rw          (rw),
    .str         (str),
    .mr          (mr),
    .rt_addr     (rt_addr),
    .rx_push     (rx_push),
    .rx_word     (rx_word),
    .tx_pop      (tx_pop),
    .tx_word     (tx_word),
    .tx_valid    (tx_valid),
    .ffempty     (ffempty),
    .rflag       (rflag),
    .error       (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [DW-1:0] d);
    cs = 1'b0; rw = 1'b0; reg_addr = a; reg_data_i = d; str = 1'b0;
    tick();
    tick();
    str = 1'b1;
    tick();
    cs = 1'b1;
    tick();
  endtask

  // Optionally pushes an RX word on the commit edge to exercise pop+push.
  task automatic bus_read(input logic [3:0] a, input logic [DW-1:0] exp, input bit push_at_commit);
    logic [DW-1:0] e;
    exp_q.push_back(exp);
    cs = 1'b0; rw = 1'b1; reg_addr = a; str = 1'b0;
    tick();
    chk("oe_early", 32'(reg_data_oe), 32'd0);
    tick();
    chk("oe_drive", 32'(reg_data_oe), 32'd1);
    e = exp_q.pop_front();
    chk($sformatf("rd_data_%0h", a), 32'(reg_data_o), 32'(e));
    rx_push = push_at_commit; rx_word = 16'h3333; str = 1'b1;
    tick();
    rx_push = 1'b0;
    chk("oe_commit", 32'(reg_data_oe), 32'd0);
    cs = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] e;
    rstn = 1'b0; cs = 1'b1; rw = 1'b1; str = 1'b1; mr = 1'b0;
    reg_addr = '0; reg_data_i = '0; rt_addr = 5'h15;
    rx_push = 1'b0; rx_word = '0; tx_pop = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    chk("rst_oe", 32'(reg_data_oe), 32'd0);
    chk("rst_data", 32'(reg_data_o), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_ffempty", 32'(ffempty), 32'd1);
    chk("rst_rflag", 32'(rflag), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Scratch, CTRL and RTADDR
    bus_write(4'h7, 16'hA5C3);
    bus_read(4'h7, 16'hA5C3, 1'b0);
    bus_write(4'h0, 16'h1234);
    bus_read(4'h0, 16'h1234, 1'b0);
    bus_read(4'h4, 16'h0015, 1'b0);

    // RX FIFO in order, ffempty after last pop
    rx_push = 1'b1; rx_word = 16'h1111;
    tick();
    rx_word = 16'h2222;
    tick();
    rx_push = 1'b0;
    chk("rflag_filled", 32'(rflag), 32'd1);
    chk("ffempty_filled", 32'(ffempty), 32'd0);
    bus_read(4'h3, 16'h1111, 1'b0);
    chk("ffempty_one_left", 32'(ffempty), 32'd0);
    bus_read(4'h3, 16'h2222, 1'b0);
    chk("ffempty_drained", 32'(ffempty), 32'd1);
    chk("rflag_drained", 32'(rflag), 32'd0);

    // Underflow and W1C
    bus_read(4'h3, 16'h0000, 1'b0);
    chk("error_unf", 32'(error), 32'd1);
    bus_read(4'h1, 16'h0045, 1'b0);
    bus_write(4'h1, 16'h0040);
    bus_read(4'h1, 16'h0005, 1'b0);
    chk("error_unf_clr", 32'(error), 32'd0);

    // TX FIFO overflow then drain
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus_write(4'h2, 16'(32'h0100 + i));
      if (i < DEPTH) tx_exp_q.push_back(16'(32'h0100 + i));
    end
    bus_read(4'h2, 16'h0000, 1'b0);
    bus_read(4'h1, 16'h0019, 1'b0);
    tx_pop = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("tx_valid_drain", 32'(tx_valid), 32'd1);
      e = tx_exp_q.pop_front();
      chk($sformatf("tx_word_%0d", i), 32'(tx_word), 32'(e));
      tick();
    end
    chk("tx_valid_empty", 32'(tx_valid), 32'd0);
    tick();
    tx_pop = 1'b0;
    chk("tx_valid_pop_empty", 32'(tx_valid), 32'd0);
    chk("error_tx_ovf", 32'(error), 32'd1);
    bus_write(4'h1, 16'h0010);
    chk("error_tx_ovf_clr", 32'(error), 32'd0);
    bus_read(4'h1, 16'h0005, 1'b0);

    // Abort: cs rises before str
    cs = 1'b0; rw = 1'b0; reg_addr = 4'h5; reg_data_i = 16'hBEEF; str = 1'b0;
    tick();
    tick();
    cs = 1'b1;
    tick();
    str = 1'b1;
    tick();
    bus_read(4'h5, 16'h0000, 1'b0);

    // RX overflow, then pop and push together while full
    rx_push = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      rx_word = 16'(32'h0200 + i);
      tick();
    end
    rx_push = 1'b0;
    bus_read(4'h1, 16'h2026, 1'b0);
    bus_write(4'h1, 16'h0020);
    bus_read(4'h3, 16'h0200, 1'b1);
    bus_read(4'h1, 16'h2006, 1'b0);
    bus_read(4'h3, 16'h0201, 1'b0);

    // Master reset mid-read
    cs = 1'b0; rw = 1'b1; reg_addr = 4'h7; str = 1'b0;
    tick();
    tick();
    chk("mr_oe_before", 32'(reg_data_oe), 32'd1);
    mr = 1'b1;
    tick();
    chk("mr_oe_after", 32'(reg_data_oe), 32'd0);
    chk("mr_data_after", 32'(reg_data_o), 32'd0);
    mr = 1'b0; str = 1'b1; cs = 1'b1;
    tick();
    chk("mr_ffempty", 32'(ffempty), 32'd1);
    chk("mr_error", 32'(error), 32'd0);
    bus_read(4'h7, 16'h0000, 1'b0);
    bus_read(4'h0, 16'h0000, 1'b0);

`ifdef HI6110_BUS_CHECK_EN
    cs = 1'b0; rw = 1'b0; reg_addr = 4'h5; str = 1'b0;
    tick();
    reg_addr = 4'h6;
    tick();
    cs = 1'b1;
    tick();
    str = 1'b1;
    tick();
    chk("proto_error", 32'(error), 32'd1);
    bus_read(4'h1, 16'h0085, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
